// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: round-robin arbiter and sequencer sharing one single-port SRAM macro
// between NUM_REQ requesters. It provides a valid/ready request channel, a fixed 1-cycle
// response, an optional grant lock for atomic sequences, and a lock idle timeout.
module sram_arb_ctrl #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_mask_i,
  input  logic [NUM_REQ-1:0]                req_wren_i,
  input  logic [NUM_REQ-1:0]                req_lock_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [DATA_WIDTH-1:0]             rsp_rdata_o,
  output logic                              sram_cs_o,
  output logic                              sram_wren_o,
  output logic [ADDR_WIDTH-1:0]             sram_addr_o,
  output logic [DATA_WIDTH-1:0]             sram_data_o,
  output logic [DATA_WIDTH/8-1:0]           sram_mask_o,
  input  logic [DATA_WIDTH-1:0]             sram_data_i,
  output logic                              lock_active_o
);

  localparam int unsigned MaskW = DATA_WIDTH / 8;
  localparam int unsigned IdW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SumW  = IdW + 1;
  localparam int unsigned CntW  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(LOCK_TIMEOUT);

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } state_e;

  state_e          r_state;
  logic [IdW-1:0]  r_rr_ptr;
  logic [IdW-1:0]  r_owner;
  logic [CntW-1:0] r_idle_cnt;
  logic            r_rsp_pend;
  logic [IdW-1:0]  r_rsp_id;
  logic            r_rsp_wr;

  logic            w_gnt_vld;
  logic [IdW-1:0]  w_gnt_id;
  logic            w_gnt_lock;
  logic            w_gnt_wren;

  // Successor of a requester index with wrap-around at NUM_REQ.
  function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
    if (32'(id) == NUM_REQ - 1) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

  // Pick the granted requester: fixed owner while locked, otherwise scan up from r_rr_ptr.
  always_comb begin : gnt_scan
    logic [SumW-1:0] sum;
    logic [IdW-1:0]  idx;
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    sum       = '0;
    idx       = '0;
    if (rst_n_i) begin
      if (r_state == StLocked) begin
        w_gnt_vld = req_valid_i[r_owner];
        w_gnt_id  = r_owner;
      end else begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          sum = {1'b0, r_rr_ptr} + SumW'(i);
          if (sum >= SumW'(NUM_REQ)) begin
            sum = sum - SumW'(NUM_REQ);
          end
          idx = sum[IdW-1:0];
          if (!w_gnt_vld && req_valid_i[idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = idx;
          end
        end
      end
    end
  end

  // Route the granted requester's fields to the SRAM; everything is zero with no grant.
  always_comb begin
    req_ready_o = '0;
    sram_cs_o   = 1'b0;
    sram_wren_o = 1'b0;
    sram_addr_o = '0;
    sram_data_o = '0;
    sram_mask_o = '0;
    w_gnt_lock  = 1'b0;
    w_gnt_wren  = 1'b0;
    if (w_gnt_vld) begin
      req_ready_o[w_gnt_id] = 1'b1;
      w_gnt_lock  = req_lock_i[w_gnt_id];
      w_gnt_wren  = req_wren_i[w_gnt_id];
      sram_cs_o   = 1'b1;
      sram_wren_o = w_gnt_wren;
      sram_addr_o = req_addr_i[32'(w_gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
      sram_data_o = req_wdata_i[32'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
      sram_mask_o = req_mask_i[32'(w_gnt_id)*MaskW +: MaskW];
    end
  end

  // Arbitration state, lock tracking with idle timeout, and response pipeline.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= StIdle;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_idle_cnt <= '0;
      r_rsp_pend <= 1'b0;
      r_rsp_id   <= '0;
      r_rsp_wr   <= 1'b0;
    end else begin
      r_rsp_pend <= w_gnt_vld;
      r_rsp_id   <= w_gnt_id;
      r_rsp_wr   <= w_gnt_vld & w_gnt_wren;
      unique case (r_state)
        StIdle: begin
          if (w_gnt_vld) begin
            if (w_gnt_lock) begin
              r_state    <= StLocked;
              r_owner    <= w_gnt_id;
              r_idle_cnt <= '0;
            end else begin
              r_rr_ptr <= next_id(w_gnt_id);
            end
          end
        end
        StLocked: begin
          if (w_gnt_vld) begin
            r_idle_cnt <= '0;
            if (!w_gnt_lock) begin
              r_state  <= StIdle;
              r_rr_ptr <= next_id(r_owner);
            end
          end else if (r_idle_cnt >= CntLast) begin
            // The counter reaches LOCK_TIMEOUT on this edge, so the lock is already gone in
            // the cycle where it reads LOCK_TIMEOUT and the owner only competes normally.
            r_idle_cnt <= CntMax;
            r_state    <= StIdle;
            r_rr_ptr   <= next_id(r_owner);
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Response pulse for last cycle's handshake; write acks and idle cycles return zero data.
  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    if (rst_n_i && r_rsp_pend) begin
      rsp_valid_o[r_rsp_id] = 1'b1;
      if (!r_rsp_wr) begin
        rsp_rdata_o = sram_data_i;
      end
    end
  end

  assign lock_active_o = rst_n_i && (r_state == StLocked);

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Testbench for sram_arb_ctrl: directed scenarios plus randomized traffic checked against a
// transaction-level reference model and a behavioural single-port SRAM.
module tb_sram_arb_ctrl;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int T  = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_wren, req_lock, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*MW-1:0] req_mask;
  logic [DW-1:0]   rsp_rdata, sram_q, sram_wdata;
  logic            sram_cs, sram_wren, lock_active;
  logic [AW-1:0]   sram_addr;
  logic [MW-1:0]   sram_mask;

  int n_vec, n_err, cyc;

  sram_arb_ctrl #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(T)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_mask_i(req_mask),
    .req_wren_i(req_wren), .req_lock_i(req_lock),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .sram_cs_o(sram_cs), .sram_wren_o(sram_wren), .sram_addr_o(sram_addr),
    .sram_data_o(sram_wdata), .sram_mask_o(sram_mask), .sram_data_i(sram_q),
    .lock_active_o(lock_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] expand(input logic [MW-1:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Behavioural tc_sram_1024x32: 1-cycle read latency, garbage on data_o after a write.
  logic [DW-1:0] sram_mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) sram_mem[i] = '0;
    sram_q = '0;
    forever begin
      @(posedge clk);
      if (sram_cs) begin
        if (sram_wren) begin
          sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~expand(sram_mask)) |
                                 (sram_wdata & expand(sram_mask));
          sram_q <= $urandom;
        end else begin
          sram_q <= sram_mem[sram_addr];
        end
      end
    end
  end

  // ---------------- reference model (transaction level) ----------------
  int            m_ptr, m_owner, m_idle, m_rsp_id;   // m_owner = -1 when no lock is held
  bit            m_rsp_pend, m_rsp_wr;
  logic [DW-1:0] m_rsp_data;
  logic [DW-1:0] ref_mem [1024];

  int            exp_gnt;
  logic [N-1:0]  exp_ready, exp_rsp_valid;
  logic          exp_cs, exp_wren, exp_lock;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_rdata;
  logic [MW-1:0] exp_mask;

  function automatic bit bit_at(input logic [N-1:0] v, input int i);
    return 1'(v >> i);
  endfunction
  function automatic logic [AW-1:0] get_addr(input int r);
    return AW'(req_addr >> (r * AW));
  endfunction
  function automatic logic [DW-1:0] get_wdata(input int r);
    return DW'(req_wdata >> (r * DW));
  endfunction
  function automatic logic [MW-1:0] get_mask(input int r);
    return MW'(req_mask >> (r * MW));
  endfunction

  task automatic model_eval();
    exp_gnt = -1;
    if (rst_n) begin
      if (m_owner >= 0) begin
        if (bit_at(req_valid, m_owner)) exp_gnt = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (exp_gnt < 0 && bit_at(req_valid, (m_ptr + k) % N)) exp_gnt = (m_ptr + k) % N;
        end
      end
    end
    exp_ready = '0; exp_cs = 0; exp_wren = 0; exp_addr = '0; exp_wdata = '0; exp_mask = '0;
    if (exp_gnt >= 0) begin
      exp_ready = N'(1) << exp_gnt;
      exp_cs    = 1'b1;
      exp_wren  = bit_at(req_wren, exp_gnt);
      exp_addr  = get_addr(exp_gnt);
      exp_wdata = get_wdata(exp_gnt);
      exp_mask  = get_mask(exp_gnt);
    end
    exp_rsp_valid = (rst_n && m_rsp_pend) ? (N'(1) << m_rsp_id) : '0;
    exp_rdata     = (rst_n && m_rsp_pend && !m_rsp_wr) ? m_rsp_data : '0;
    exp_lock      = rst_n && (m_owner >= 0);
  endtask

  task automatic model_commit();
    int g;
    cyc++;
    if (!rst_n) begin
      m_ptr = 0; m_owner = -1; m_idle = 0; m_rsp_pend = 0;
      return;
    end
    m_rsp_pend = (exp_gnt >= 0);
    if (exp_gnt >= 0) begin
      g = exp_gnt;
      m_rsp_id = g;
      m_rsp_wr = bit_at(req_wren, g);
      if (m_rsp_wr) begin
        ref_mem[get_addr(g)] = (ref_mem[get_addr(g)] & ~expand(get_mask(g))) |
                               (get_wdata(g) & expand(get_mask(g)));
      end else begin
        m_rsp_data = ref_mem[get_addr(g)];
      end
      if (m_owner < 0) begin
        if (bit_at(req_lock, g)) begin m_owner = g; m_idle = 0; end
        else m_ptr = (g + 1) % N;
      end else begin
        m_idle = 0;
        if (!bit_at(req_lock, g)) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
      end
    end else if (m_owner >= 0) begin
      m_idle++;
      if (m_idle >= T) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int r, input bit v, input bit w, input bit l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [MW-1:0] m);
    req_valid = (req_valid & ~(N'(1) << r)) | (N'(v) << r);
    req_wren  = (req_wren & ~(N'(1) << r)) | (N'(w) << r);
    req_lock  = (req_lock & ~(N'(1) << r)) | (N'(l) << r);
    req_addr  = (req_addr & ~((N*AW)'({AW{1'b1}}) << (r*AW))) | ((N*AW)'(a) << (r*AW));
    req_wdata = (req_wdata & ~((N*DW)'({DW{1'b1}}) << (r*DW))) | ((N*DW)'(d) << (r*DW));
    req_mask  = (req_mask & ~((N*MW)'({MW{1'b1}}) << (r*MW))) | ((N*MW)'(m) << (r*MW));
  endtask

  task automatic clear_reqs();
    req_valid = '0; req_wren = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0; req_mask = '0;
  endtask

  task automatic at_sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    at_sample();
    advance();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 1, 0, 1, 10'h001, 32'h1, 4'hF);
    set_req(1, 1, 1, 1, 10'h002, 32'h2, 4'hF);
    for (int i = 0; i < 2; i++) begin
      at_sample();
      n_vec++;
      if ({req_ready, sram_cs, lock_active, rsp_valid} !== '0) begin
        n_err++;
        $display("FAIL reset_forced: ready=%b cs=%b lock=%b rsp=%b, want all 0",
                 req_ready, sram_cs, lock_active, rsp_valid);
      end
      advance();
    end
    rst_n = 1'b1;
    clear_reqs();
    at_sample();
    n_vec++;
    if (rsp_valid !== 2'b00) begin
      n_err++; $display("FAIL reset_first_rsp: got %b want 00", rsp_valid);
    end
    n_vec++;
    if ({req_ready, sram_cs, sram_wren, sram_addr, sram_wdata, sram_mask, lock_active} !== '0)
    begin
      n_err++;
      $display("FAIL reset_idle_outputs: cs=%b addr=%h data=%h mask=%h lock=%b, want 0",
               sram_cs, sram_addr, sram_wdata, sram_mask, lock_active);
    end
    advance();
  endtask

  task automatic test_write_read();
    do_reset();
    set_req(0, 1, 1, 0, 10'h005, 32'hDEADBEEF, 4'hF);
    at_sample();
    n_vec++;
    if ({req_ready, sram_cs, sram_wren, sram_addr, sram_wdata, sram_mask} !==
        {2'b01, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF}) begin
      n_err++;
      $display("FAIL wr_drive: ready=%b cs=%b we=%b addr=%h data=%h mask=%h", req_ready,
               sram_cs, sram_wren, sram_addr, sram_wdata, sram_mask);
    end
    advance();
    set_req(0, 1, 0, 0, 10'h005, 32'h0, 4'hF);
    at_sample();
    n_vec++;
    if ({rsp_valid, rsp_rdata} !== {2'b01, 32'h0}) begin
      n_err++; $display("FAIL wr_ack: got rsp=%b data=%h want 01/0", rsp_valid, rsp_rdata);
    end
    n_vec++;
    if ({req_ready, sram_cs, sram_wren} !== {2'b01, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL rd_drive: ready=%b cs=%b we=%b", req_ready, sram_cs, sram_wren);
    end
    advance();
    clear_reqs();
    at_sample();
    n_vec++;
    if ({rsp_valid, rsp_rdata} !== {2'b01, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL rd_data: got rsp=%b data=%h want 01/deadbeef", rsp_valid, rsp_rdata);
    end
    n_vec++;
    if ({req_ready, sram_cs, sram_addr} !== '0) begin
      n_err++; $display("FAIL no_grant_zero: ready=%b cs=%b addr=%h", req_ready, sram_cs,
                        sram_addr);
    end
    advance();
  endtask

  task automatic test_byte_mask();
    do_reset();
    set_req(0, 1, 1, 0, 10'h3FF, 32'h0, 4'hF);
    at_sample(); advance();
    set_req(0, 1, 1, 0, 10'h3FF, 32'h11223344, 4'h5);
    at_sample(); advance();
    set_req(0, 1, 0, 0, 10'h3FF, 32'h0, 4'hA);
    at_sample();
    n_vec++;
    if ({sram_cs, sram_wren, sram_mask} !== {1'b1, 1'b0, 4'hA}) begin
      n_err++; $display("FAIL rd_mask_pass: cs=%b we=%b mask=%h want 1/0/a", sram_cs,
                        sram_wren, sram_mask);
    end
    advance();
    clear_reqs();
    at_sample();
    n_vec++;
    if ({rsp_valid, rsp_rdata} !== {2'b01, 32'h00220044}) begin
      n_err++;
      $display("FAIL byte_mask: got rsp=%b data=%h want 01/00220044", rsp_valid, rsp_rdata);
    end
    advance();
  endtask

  task automatic test_round_robin();
    int cnt0, cnt1;
    logic [N-1:0]  want_rdy;
    logic [AW-1:0] want_addr;
    cnt0 = 0; cnt1 = 0;
    do_reset();
    set_req(0, 1, 0, 0, 10'h010, 32'h0, 4'hF);
    set_req(1, 1, 0, 0, 10'h020, 32'h0, 4'hF);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) clear_reqs();
      at_sample();
      cnt0 += int'(rsp_valid[0]);
      cnt1 += int'(rsp_valid[1]);
      if (i < 6) begin
        want_rdy  = (i % 2 == 0) ? 2'b01 : 2'b10;
        want_addr = (i % 2 == 0) ? 10'h010 : 10'h020;
        n_vec++;
        if ({req_ready, sram_cs, sram_addr} !== {want_rdy, 1'b1, want_addr}) begin
          n_err++;
          $display("FAIL rr_grant[%0d]: ready=%b cs=%b addr=%h want %b/1/%h", i, req_ready,
                   sram_cs, sram_addr, want_rdy, want_addr);
        end
      end
      advance();
    end
    n_vec++;
    if (cnt0 != 3 || cnt1 != 3) begin
      n_err++; $display("FAIL rr_rsp_count: got %0d/%0d want 3/3", cnt0, cnt1);
    end
  endtask

  task automatic test_lock();
    logic [N-1:0] want_rdy;
    logic         want_lk;
    do_reset();
    set_req(0, 1, 0, 0, 10'h001, 32'h0, 4'hF);
    at_sample(); advance();  // moves the round-robin pointer to requester 1
    for (int b = 0; b < 4; b++) begin
      if (b < 3) set_req(1, 1, 1, (b < 2), 10'(10'h040 + b), 32'(b), 4'hF);
      else set_req(1, 0, 0, 0, 10'h0, 32'h0, 4'h0);
      at_sample();
      want_rdy = (b < 3) ? 2'b10 : 2'b01;
      want_lk  = (b == 1 || b == 2);
      n_vec++;
      if (req_ready !== want_rdy) begin
        n_err++; $display("FAIL lock_grant[%0d]: got %b want %b", b, req_ready, want_rdy);
      end
      n_vec++;
      if (lock_active !== want_lk) begin
        n_err++; $display("FAIL lock_active[%0d]: got %b want %b", b, lock_active, want_lk);
      end
      advance();
    end
    clear_reqs();
  endtask

  // owner_back: the owner re-asserts valid exactly in the timeout cycle.
  task automatic run_timeout(input bit owner_back);
    logic [N-1:0] want_rdy;
    do_reset();
    set_req(0, 1, 0, 1, 10'h003, 32'h0, 4'hF);
    set_req(1, 1, 0, 0, 10'h004, 32'h0, 4'hF);
    at_sample();
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL tmo_lock_beat: got %b want 01", req_ready);
    end
    advance();
    set_req(0, 0, 0, 0, 10'h003, 32'h0, 4'hF);
    for (int k = 1; k <= T + 1; k++) begin
      if (k == T + 1 && owner_back) set_req(0, 1, 0, 0, 10'h003, 32'h0, 4'hF);
      at_sample();
      want_rdy = (k == T + 1) ? 2'b10 : 2'b00;
      n_vec++;
      if ({req_ready, lock_active} !== {want_rdy, (k <= T)}) begin
        n_err++;
        $display("FAIL tmo_cycle[%0d,%0d]: ready=%b lock=%b want %b/%b", owner_back, k,
                 req_ready, lock_active, want_rdy, (k <= T));
      end
      advance();
    end
    if (owner_back) begin
      set_req(1, 0, 0, 0, 10'h0, 32'h0, 4'h0);
      at_sample();
      n_vec++;
      if (req_ready !== 2'b01) begin
        n_err++; $display("FAIL tmo_owner_rr: got %b want 01", req_ready);
      end
      advance();
    end
    clear_reqs();
  endtask

  task automatic test_lock_timeout();
    run_timeout(1'b0);
    run_timeout(1'b1);
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    set_req(0, 1, 0, 1, 10'h005, 32'h0, 4'hF);
    at_sample();
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL rml_beat: got %b want 01", req_ready);
    end
    advance();
    rst_n = 1'b0;
    set_req(0, 0, 0, 0, 10'h0, 32'h0, 4'h0);
    set_req(1, 1, 0, 0, 10'h006, 32'h0, 4'hF);
    at_sample();
    n_vec++;
    if ({rsp_valid, req_ready, lock_active} !== '0) begin
      n_err++; $display("FAIL rml_in_reset: rsp=%b ready=%b lock=%b want 0", rsp_valid,
                        req_ready, lock_active);
    end
    advance();
    rst_n = 1'b1;
    at_sample();
    n_vec++;
    if ({rsp_valid, req_ready, lock_active} !== {2'b00, 2'b10, 1'b0}) begin
      n_err++; $display("FAIL rml_after: rsp=%b ready=%b lock=%b want 00/10/0", rsp_valid,
                        req_ready, lock_active);
    end
    advance();
    clear_reqs();
  endtask

  task automatic test_random();
    int pct;
    pct = 50;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if (c % 250 == 0) begin
        case ((c / 250) % 3)
          0:       pct = 90;
          1:       pct = 50;
          default: pct = 8;
        endcase
      end
      rst_n = ($urandom_range(0, 399) != 0);
      for (int r = 0; r < N; r++) begin
        // A requester waiting for its grant keeps its request unchanged.
        if (!(bit_at(req_valid, r) && exp_gnt != r)) begin
          set_req(r, ($urandom_range(0, 99) < pct), 1'($urandom), ($urandom_range(0, 3) == 0),
                  AW'($urandom_range(0, 7)), $urandom, MW'($urandom));
        end
      end
      at_sample();
      n_vec++;
      if (req_ready !== exp_ready) begin
        n_err++; $display("FAIL rnd_ready @%0d: got %b want %b", cyc, req_ready, exp_ready);
      end
      n_vec++;
      if ({sram_cs, sram_wren, sram_addr, sram_wdata, sram_mask} !==
          {exp_cs, exp_wren, exp_addr, exp_wdata, exp_mask}) begin
        n_err++;
        $display("FAIL rnd_sram @%0d: got %b/%b/%h/%h/%h want %b/%b/%h/%h/%h", cyc, sram_cs,
                 sram_wren, sram_addr, sram_wdata, sram_mask, exp_cs, exp_wren, exp_addr,
                 exp_wdata, exp_mask);
      end
      n_vec++;
      if ({rsp_valid, rsp_rdata} !== {exp_rsp_valid, exp_rdata}) begin
        n_err++; $display("FAIL rnd_rsp @%0d: got %b/%h want %b/%h", cyc, rsp_valid,
                          rsp_rdata, exp_rsp_valid, exp_rdata);
      end
      n_vec++;
      if (lock_active !== exp_lock) begin
        n_err++; $display("FAIL rnd_lock @%0d: got %b want %b", cyc, lock_active, exp_lock);
      end
      advance();
    end
    rst_n = 1'b1;
    clear_reqs();
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    m_ptr = 0; m_owner = -1; m_idle = 0; m_rsp_id = 0;
    m_rsp_pend = 0; m_rsp_wr = 0; m_rsp_data = '0; exp_gnt = -1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    rst_n = 1'b0;
    clear_reqs();
    #1;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_round_robin();
    test_lock();
    test_lock_timeout();
    test_reset_mid_lock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
